// File: rtl/ch_inst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ch_inst_sequencer
//  Description : Issues the per-channel INST_START / INST_STOP / INST_READOUT
//                pulses from host commands and synchronized channel stop
//                requests, then walks a channel-by-channel readout handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module ch_inst_sequencer #(
    parameter int NUM_CH        = 8,
    parameter int PULSE_LEN     = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2,
    localparam int c_CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic              cmd_readout,
    input  logic              auto_readout,
    input  logic              auto_rearm,
    input  logic [NUM_CH-1:0] stop_request,
    input  logic              rd_ack,
    output logic              inst_start,
    output logic              inst_stop,
    output logic              inst_readout,
    output logic              rd_req,
    output logic [c_CH_W-1:0] rd_ch,
    output logic [NUM_CH-1:0] stop_src,
    output logic [2:0]        seq_state,
    output logic              busy
);

    // State encoding doubles as the debug SEQ_STATE value
    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_START_P = 3'd1;
    localparam logic [2:0] c_RUN     = 3'd2;
    localparam logic [2:0] c_STOP_P  = 3'd3;
    localparam logic [2:0] c_SETTLE  = 3'd4;
    localparam logic [2:0] c_STOPPED = 3'd5;
    localparam logic [2:0] c_RDO_P   = 3'd6;
    localparam logic [2:0] c_RDO_CH  = 3'd7;

    localparam logic [7:0] c_PULSE_LAST  = 8'(PULSE_LEN - 1);
    localparam logic [7:0] c_SETTLE_LAST = (SETTLE_CYCLES > 0) ? 8'(SETTLE_CYCLES - 1) : 8'd0;
    // With no settle time the stop pulse hands straight over to STOPPED
    localparam logic [2:0] c_POST_STOP   = (SETTLE_CYCLES > 0) ? c_SETTLE : c_STOPPED;
    localparam logic [c_CH_W-1:0] c_LAST_CH = c_CH_W'(NUM_CH - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [7:0]        r_cnt;
    logic [7:0]        w_cnt_next;
    logic [NUM_CH-1:0] r_sync [SYNC_STAGES];
    logic [NUM_CH-1:0] w_sync;
    logic              w_sreq;
    logic              w_pulse_done;
    logic              w_ack;
    logic              r_inst_start;
    logic              r_inst_stop;
    logic              r_inst_readout;
    logic              r_rd_req;
    logic [c_CH_W-1:0] r_rd_ch;
    logic [NUM_CH-1:0] r_stop_src;
    logic              r_busy;

    assign w_sync       = r_sync[SYNC_STAGES-1];
    assign w_sreq       = |w_sync;
    assign w_pulse_done = (r_cnt >= c_PULSE_LAST);
    // An acknowledge only counts while a request is actually outstanding
    assign w_ack        = r_rd_req & rd_ack;

    // Multi-flop synchronizer for the asynchronous channel stop requests
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= stop_request;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Next-state and shared pulse/settle counter decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:    if (cmd_start) w_next = c_START_P;
            c_START_P: if (w_pulse_done) w_next = c_RUN;
            c_RUN:     if (cmd_stop || w_sreq) w_next = c_STOP_P;
            c_STOP_P:  if (w_pulse_done) w_next = c_POST_STOP;
            c_SETTLE:  if (r_cnt >= c_SETTLE_LAST) w_next = c_STOPPED;
            c_STOPPED: begin
                // Readout wins over a simultaneous re-arm request
                if (cmd_readout || auto_readout) begin
                    w_next = c_RDO_P;
                end else if (cmd_start) begin
                    w_next = c_START_P;
                end
            end
            c_RDO_P:   if (w_pulse_done) w_next = c_RDO_CH;
            c_RDO_CH: begin
                if (w_ack && (r_rd_ch == c_LAST_CH)) begin
                    w_next = auto_rearm ? c_START_P : c_IDLE;
                end
            end
            default:   w_next = c_IDLE;
        endcase

        // Counter restarts on every state change and saturates otherwise
        if (w_next != r_state) begin
            w_cnt_next = 8'd0;
        end else if (r_cnt == 8'hFF) begin
            w_cnt_next = r_cnt;
        end else begin
            w_cnt_next = r_cnt + 8'd1;
        end
    end

    // State, registered pulse outputs, stop snapshot and readout handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= c_IDLE;
            r_cnt          <= 8'd0;
            r_inst_start   <= 1'b0;
            r_inst_stop    <= 1'b0;
            r_inst_readout <= 1'b0;
            r_rd_req       <= 1'b0;
            r_rd_ch        <= '0;
            r_stop_src     <= '0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_cnt          <= w_cnt_next;
            // Pulses decode the next state so they line up with the state flop
            r_inst_start   <= (w_next == c_START_P);
            r_inst_stop    <= (w_next == c_STOP_P);
            r_inst_readout <= (w_next == c_RDO_P);
            r_busy         <= (w_next != c_IDLE) && (w_next != c_STOPPED);

            // Snapshot is zero for a purely host-initiated stop
            if ((r_state == c_RUN) && (w_next == c_STOP_P)) begin
                r_stop_src <= w_sync;
            end

            // Request low on entry and for one cycle after each ack
            if ((r_state == c_RDO_CH) && (w_next == c_RDO_CH)) begin
                r_rd_req <= r_rd_req ? ~rd_ack : 1'b1;
            end else begin
                r_rd_req <= 1'b0;
            end

            if (w_next != c_RDO_CH) begin
                r_rd_ch <= '0;
            end else if ((r_state == c_RDO_CH) && w_ack) begin
                r_rd_ch <= r_rd_ch + c_CH_W'(1);
            end
        end
    end

    assign inst_start   = r_inst_start;
    assign inst_stop    = r_inst_stop;
    assign inst_readout = r_inst_readout;
    assign rd_req       = r_rd_req;
    assign rd_ch        = r_rd_ch;
    assign stop_src     = r_stop_src;
    assign seq_state    = r_state;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ch_inst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ch_inst_sequencer
//  Description : Self-checking bench for ch_inst_sequencer; directed steps
//                with randomized gaps, vectors and ack delays.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ch_inst_sequencer;

    localparam int NUM_CH        = 8;
    localparam int PULSE_LEN     = 2;
    localparam int SETTLE_CYCLES = 4;
    localparam int SYNC_STAGES   = 2;
    localparam int CH_W          = $clog2(NUM_CH);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_start = 1'b0;
    logic              cmd_stop = 1'b0;
    logic              cmd_readout = 1'b0;
    logic              auto_readout = 1'b0;
    logic              auto_rearm = 1'b0;
    logic [NUM_CH-1:0] stop_request = '0;
    logic              rd_ack = 1'b0;
    logic              inst_start;
    logic              inst_stop;
    logic              inst_readout;
    logic              rd_req;
    logic [CH_W-1:0]   rd_ch;
    logic [NUM_CH-1:0] stop_src;
    logic [2:0]        seq_state;
    logic              busy;

    int                n_tests = 0;
    int                n_fail  = 0;
    // Model: the STOP_SRC value the bench expects to be held
    logic [NUM_CH-1:0] exp_src = '0;

    ch_inst_sequencer #(
        .NUM_CH(NUM_CH), .PULSE_LEN(PULSE_LEN),
        .SETTLE_CYCLES(SETTLE_CYCLES), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cmd_readout(cmd_readout), .auto_readout(auto_readout),
        .auto_rearm(auto_rearm), .stop_request(stop_request), .rd_ack(rd_ack),
        .inst_start(inst_start), .inst_stop(inst_stop),
        .inst_readout(inst_readout), .rd_req(rd_req), .rd_ch(rd_ch),
        .stop_src(stop_src), .seq_state(seq_state), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sel_sig(input int sel);
        case (sel)
            0:       return inst_start;
            1:       return inst_stop;
            default: return inst_readout;
        endcase
    endfunction

    // Counts consecutive high cycles of a pulse, starting at the current sample
    task automatic pulse_width(input int sel, output int w);
        w = 0;
        while (sel_sig(sel) && w < 64) begin
            w++;
            tick();
        end
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
        int n;
        n = 0;
        while (seq_state !== st && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(seq_state), 32'(st));
    endtask

    task automatic do_start();
        int w;
        repeat ($urandom_range(0, 3)) tick();
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        check("start_rise", 32'(inst_start), 1);
        pulse_width(0, w);
        check("start_width", w, PULSE_LEN);
        check("run_state", 32'(seq_state), 2);
        check("run_busy", 32'(busy), 1);
        // A start while running must not produce another pulse
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        check("run_ignores_start", 32'({inst_start, seq_state}), 32'({1'b0, 3'd2}));
    endtask

    task automatic do_host_stop();
        int w;
        int n;
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        exp_src = '0;
        check("hstop_rise", 32'(inst_stop), 1);
        pulse_width(1, w);
        check("hstop_width", w, PULSE_LEN);
        n = 0;
        while (seq_state !== 3'd5 && n < 300) begin
            check("settle_quiet", 32'({inst_start, inst_stop, inst_readout}), 0);
            tick();
            n++;
        end
        check("settle_len", n, SETTLE_CYCLES);
        check("hstop_src", 32'(stop_src), 32'(exp_src));
        check("stopped_busy", 32'(busy), 0);
    endtask

    task automatic do_chan_stop(input logic [NUM_CH-1:0] vec);
        int n;
        int w;
        #3 stop_request = vec;
        n = 0;
        while (!inst_stop && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        exp_src = vec;
        check("cstop_latency", n, SYNC_STAGES + 1);
        check("cstop_src", 32'(stop_src), 32'(exp_src));
        pulse_width(1, w);
        check("cstop_width", w, PULSE_LEN);
        stop_request = '0;
        wait_state(3'd5, 300, "cstop_stopped");
        // Requests outside RUN must leave the snapshot alone
        stop_request = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
        repeat (3) tick();
        check("src_hold_stopped", 32'(stop_src), 32'(exp_src));
        stop_request = '0;
        repeat (3) tick();
    endtask

    task automatic do_readout(input bit rearm, input int mode, input int abort_at);
        int w;
        auto_rearm = rearm;
        if (mode == 0) begin
            auto_readout = 1'b1;
        end else begin
            cmd_readout = 1'b1;
            cmd_start   = (mode == 2);
        end
        tick();
        cmd_readout = 1'b0;
        cmd_start   = 1'b0;
        check("rdo_prio", 32'({inst_readout, inst_start}), 32'(2'b10));
        pulse_width(2, w);
        check("rdo_width", w, PULSE_LEN);
        check("rdo_entry", 32'({seq_state, rd_req, rd_ch}), 32'({3'd7, 1'b0, CH_W'(0)}));
        for (int i = 0; i < NUM_CH; i++) begin
            tick();
            rd_ack = 1'b0;
            check("req_rise", 32'(rd_req), 1);
            check("rd_ch", 32'(rd_ch), i);
            if (i == abort_at) begin
                #2 rst = 1'b1;
                #1;
                check("abort_inst", 32'({inst_start, inst_stop, inst_readout}), 0);
                check("abort_hs", 32'({rd_req, rd_ch}), 0);
                check("abort_state", 32'({seq_state, busy}), 0);
                check("abort_src", 32'(stop_src), 0);
                exp_src = '0;
                tick();
                rst = 1'b0;
                auto_readout = 1'b0;
                tick();
                check("abort_idle", 32'(seq_state), 0);
                return;
            end
            repeat ($urandom_range(0, 2)) begin
                tick();
                check("req_hold", 32'(rd_req), 1);
            end
            rd_ack = 1'b1;
            tick();
            // Optionally keep ack high in the low cycle; it must be ignored
            rd_ack = 1'($urandom_range(0, 1));
            check("req_drop", 32'(rd_req), 0);
            if (i < NUM_CH - 1) begin
                check("rd_ch_step", 32'({seq_state, rd_ch}), 32'({3'd7, CH_W'(i + 1)}));
            end else begin
                rd_ack = 1'b0;
                check("rd_ch_wrap", 32'(rd_ch), 0);
                if (rearm) begin
                    check("rearm_rise", 32'(inst_start), 1);
                    pulse_width(0, w);
                    check("rearm_width", w, PULSE_LEN);
                    check("rearm_run", 32'(seq_state), 2);
                end else begin
                    check("walk_idle", 32'({seq_state, busy}), 0);
                end
            end
        end
        auto_readout = 1'b0;
        check("src_hold_rdo", 32'(stop_src), 32'(exp_src));
    endtask

    task automatic idle_ignore();
        logic any;
        any = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_stop    = (i == 0);
            cmd_readout = (i == 2);
            tick();
            any = any | inst_start | inst_stop | inst_readout | rd_req;
        end
        cmd_stop    = 1'b0;
        cmd_readout = 1'b0;
        check("idle_ignore", 32'({any, seq_state}), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [NUM_CH-1:0] vec;
        bit                in_run;
        bit                rearm;

        // Reset state
        repeat (3) tick();
        check("rst_outputs", 32'({inst_start, inst_stop, inst_readout, rd_req, rd_ch, busy}), 0);
        check("rst_state", 32'({seq_state, stop_src}), 0);
        rst = 1'b0;
        tick();
        check("post_rst_idle", 32'(seq_state), 0);

        idle_ignore();

        // Start then host stop
        do_start();
        do_host_stop();

        // Channel stop with the documented vector, then re-arm from STOPPED
        do_start();
        do_chan_stop(8'h20);
        do_start();
        check("src_after_rearm", 32'(stop_src), 32'h20);

        // Simultaneous host stop and synchronized channel request
        vec = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
        stop_request = vec;
        tick();
        tick();
        cmd_stop = 1'b1;
        tick();
        cmd_stop = 1'b0;
        exp_src = vec;
        check("both_stop_rise", 32'({inst_stop, seq_state}), 32'({1'b1, 3'd3}));
        check("both_stop_src", 32'(stop_src), 32'(exp_src));
        begin
            int w;
            pulse_width(1, w);
            check("both_stop_width", w, PULSE_LEN);
        end
        stop_request = '0;
        wait_state(3'd5, 300, "both_stopped");
        repeat (3) tick();
        check("both_single", 32'({inst_stop, seq_state}), 32'({1'b0, 3'd5}));

        // Readout walk ending in IDLE
        do_readout(1'b0, 0, NUM_CH);

        // Auto re-arm with readout/start collision in STOPPED
        do_start();
        do_host_stop();
        do_readout(1'b1, 2, NUM_CH);
        do_host_stop();
        do_readout(1'b0, 1, NUM_CH);

        // Randomized rounds
        in_run = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!in_run) do_start();
            vec = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
            do_chan_stop(vec);
            rearm = 1'($urandom_range(0, 1));
            do_readout(rearm, int'($urandom_range(0, 2)), NUM_CH);
            in_run = rearm;
        end
        if (in_run) do_host_stop();
        else begin
            do_start();
            do_host_stop();
        end

        // Abort mid-readout at channel 3
        do_readout(1'b0, 0, 3);
        idle_ignore();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
